// File: rtl/pipe_isa_pkg.sv
// -----------------------------------------------------------------------------
// pipe_isa_pkg
// Shared instruction-set definitions for the fetch/issue stage and the
// downstream register/ALU/memory pipeline.
//   - INSTR_W and the bit positions of every instruction field
//   - function codes (ADD, SUB, MUL, SLA, HLT)
//   - decoded-instruction struct and fetch FSM state type
//   - decode helpers shared by every consumer of an instruction word
// -----------------------------------------------------------------------------
package pipe_isa_pkg;

  localparam int INSTR_W  = 24;

  localparam int FUNC_MSB = 23;
  localparam int FUNC_LSB = 20;
  localparam int RS1_MSB  = 19;
  localparam int RS1_LSB  = 16;
  localparam int RS2_MSB  = 15;
  localparam int RS2_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_MUL = 4'd2,
    FN_SLA = 4'd11,
    FN_HLT = 4'd15
  } func_e;

  // Field order matches the instruction word, so the struct is exactly INSTR_W bits.
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
    instr_t d;
    d.func = word[FUNC_MSB:FUNC_LSB];
    d.rs1  = word[RS1_MSB:RS1_LSB];
    d.rs2  = word[RS2_MSB:RS2_LSB];
    d.rd   = word[RD_MSB:RD_LSB];
    d.addr = word[ADDR_MSB:ADDR_LSB];
    return d;
  endfunction

  function automatic logic is_hlt(input instr_t d);
    return (d.func == FN_HLT);
  endfunction

endpackage

// File: rtl/pipe_ifetch_if.sv
// -----------------------------------------------------------------------------
// pipe_ifetch_if
// Control, program-load and issue bundle of the fetch/issue stage.
//   master : drives start/stall/load_*, observes the issue fields and status
//   slave  : the fetch stage itself
// Signals:
//   start, stall            run control
//   load_en/addr/data       instruction memory write port
//   func/rs1/rs2/rd/addr    issued instruction fields, qualified by valid
//   pc, busy, halted        fetch address and FSM status
// -----------------------------------------------------------------------------
interface pipe_ifetch_if #(
  parameter int PC_W = 6
);
  import pipe_isa_pkg::*;

  logic               start;
  logic               stall;
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;

  logic [3:0]         func;
  logic [3:0]         rs1;
  logic [3:0]         rs2;
  logic [3:0]         rd;
  logic [7:0]         addr;
  logic               valid;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               halted;

  modport master (
    output start, stall, load_en, load_addr, load_data,
    input  func, rs1, rs2, rd, addr, valid, pc, busy, halted
  );

  modport slave (
    input  start, stall, load_en, load_addr, load_data,
    output func, rs1, rs2, rd, addr, valid, pc, busy, halted
  );

endinterface

// File: rtl/pipe_imem.sv
// -----------------------------------------------------------------------------
// pipe_imem
// Single-write-port instruction RAM with a registered (synchronous) read.
// A write and a read to the same address in one cycle return the new data,
// so a word loaded together with a start pulse is what gets fetched.
// Ports:
//   clk, rst   clock; rst clears only the read-data register, never the array
//   we/waddr/wdata   write port
//   re/raddr         read enable and address; rdata holds while re is low
//   rdata            read-data register
// -----------------------------------------------------------------------------
module pipe_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // Array write; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read-data register with write-through for same-address collisions
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_r <= wdata;
      end else begin
        rdata_r <= mem_r[raddr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pipe_ifetch.sv
// -----------------------------------------------------------------------------
// pipe_ifetch
// Instruction fetch/issue stage in front of the register/ALU/memory pipeline.
// Steps a PC through a loadable instruction RAM and issues one decoded
// instruction per cycle with a valid qualifier; supports stall, halt on HLT
// and restart from PC 0.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset (memory contents are kept)
//   bus   pipe_ifetch_if.slave: start/stall/load_* in; func/rs1/rs2/rd/addr,
//         valid, pc, busy, halted out (all driven from registers)
// Build option:
//   RAW_INTERLOCK_EN  when defined, a HAZ_WIN-deep scoreboard of issued rd
//                     values inserts bubbles until a candidate's rs1/rs2 no
//                     longer matches; otherwise instructions issue back to back.
// Timing: the RAM is read at the address the PC is about to take, so the
// fetched word sits in the read register while pc points at it; its fields
// reach the outputs on the next edge.  First valid output is two cycles after
// the start pulse.
// -----------------------------------------------------------------------------
module pipe_ifetch
  import pipe_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = 6,
  parameter int HAZ_WIN    = 2
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ifetch_if.slave bus
);

  if ((PC_W != $clog2(IMEM_DEPTH)) || (HAZ_WIN < 1)) begin : g_bad_cfg
    $error("pipe_ifetch: PC_W must equal clog2(IMEM_DEPTH) and HAZ_WIN must be at least 1");
  end

  fetch_state_e       state_r;
  fetch_state_e       next_state_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_next_s;
  logic               rvld_r;
  instr_t             out_r;
  logic               valid_r;
  logic               busy_r;
  logic               halted_r;

  logic               launch_s;
  logic               issue_s;
  logic               bubble_s;
  logic               halt_s;
  logic               hazard_s;
  logic               mem_we_s;
  logic               mem_re_s;
  logic [INSTR_W-1:0] rdata_s;
  instr_t             cand_s;

  assign cand_s = decode_instr(rdata_s);

  pipe_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (PC_W),
    .DW    (INSTR_W)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (mem_re_s),
    .raddr (pc_next_s),
    .rdata (rdata_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and per-cycle issue decision
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    issue_s      = 1'b0;
    bubble_s     = 1'b0;
    halt_s       = 1'b0;
    mem_we_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        mem_we_s = bus.load_en;
        if (bus.start) begin
          next_state_s = ST_RUN;
          launch_s     = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_RUN: begin
        // HLT is checked before the hazard so a halt never waits on the scoreboard
        if (bus.stall || !rvld_r) begin
          next_state_s = ST_RUN;
        end else if (is_hlt(cand_s)) begin
          next_state_s = ST_HALT;
          halt_s       = 1'b1;
        end else if (hazard_s) begin
          bubble_s = 1'b1;
        end else begin
          issue_s = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Fetch address: PC 0 on launch, advance on issue, otherwise hold (wraps naturally)
  always_comb begin
    if (launch_s) begin
      pc_next_s = {PC_W{1'b0}};
    end else if (issue_s) begin
      pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign mem_re_s = launch_s | issue_s;

  // PC, prefetch-valid flag, issue registers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= {PC_W{1'b0}};
      rvld_r   <= 1'b0;
      out_r    <= {INSTR_W{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_next_s;
      busy_r   <= (next_state_s == ST_RUN);
      halted_r <= (next_state_s == ST_HALT);
      if (launch_s) begin
        rvld_r  <= 1'b1;
        valid_r <= 1'b0;
      end else if (halt_s) begin
        // HLT is swallowed; the prefetched word is dropped with it
        rvld_r  <= 1'b0;
        valid_r <= 1'b0;
      end else if (issue_s) begin
        out_r   <= cand_s;
        valid_r <= 1'b1;
      end else if (bubble_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

`ifdef RAW_INTERLOCK_EN
  logic [HAZ_WIN-1:0]      sb_vld_r;
  logic [HAZ_WIN-1:0][3:0] sb_rd_r;

  // Candidate sources against every outstanding destination in the window
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      hazard_s = hazard_s | (sb_vld_r[i] &
                 ((sb_rd_r[i] == cand_s.rs1) | (sb_rd_r[i] == cand_s.rs2)));
    end
  end

  // Scoreboard shift: issued rd or an empty slot per bubble; frozen otherwise
  always_ff @(posedge clk) begin
    if (rst || launch_s) begin
      sb_vld_r <= {HAZ_WIN{1'b0}};
      sb_rd_r  <= {(HAZ_WIN*4){1'b0}};
    end else if (issue_s || bubble_s) begin
      sb_vld_r[0] <= issue_s;
      sb_rd_r[0]  <= cand_s.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_vld_r[i] <= sb_vld_r[i-1];
        sb_rd_r[i]  <= sb_rd_r[i-1];
      end
    end else begin
      sb_vld_r <= sb_vld_r;
      sb_rd_r  <= sb_rd_r;
    end
  end
`else
  assign hazard_s = 1'b0;
`endif

  assign bus.func   = out_r.func;
  assign bus.rs1    = out_r.rs1;
  assign bus.rs2    = out_r.rs2;
  assign bus.rd     = out_r.rd;
  assign bus.addr   = out_r.addr;
  assign bus.valid  = valid_r;
  assign bus.pc     = pc_r;
  assign bus.busy   = busy_r;
  assign bus.halted = halted_r;

endmodule
